// File: rtl/yas_pkg.sv
// Shared types and constants for the YAS router input stage.
// Header layout: [7:6] destination address, [5:0] payload length minus one.
package yas_pkg;
  localparam int DATA_WIDTH   = 8;
  localparam int DATA_SIZE    = 6;
  localparam int NUM_CH       = 3;
  localparam int HDR_ADDR_LSB = 6;
  localparam int HDR_ADDR_W   = 2;
  localparam int HDR_LEN_LSB  = 0;

  localparam logic [DATA_WIDTH-1:0] CRC_POLY = 8'h07;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PAYLOAD,
    ST_CRC,
    ST_DROP
  } rx_state_e;

  // CRC-8, MSB first, no reflection; one full byte per call.
  function automatic logic [DATA_WIDTH-1:0] crc8_next(
    input logic [DATA_WIDTH-1:0] crc,
    input logic [DATA_WIDTH-1:0] din
  );
    logic [DATA_WIDTH-1:0] c;
    c = crc ^ din;
    for (int i = 0; i < DATA_WIDTH; i++)
      c = c[DATA_WIDTH-1] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    return c;
  endfunction
endpackage

// File: rtl/yas_crc8.sv
// Running CRC-8 register. When clr and en coincide the byte is folded
// into a zero seed, so a header byte starts a fresh CRC in one cycle.
module yas_crc8
  import yas_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] crc
);
  logic [DATA_WIDTH-1:0] seed;

  assign seed = clr ? '0 : crc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   crc <= '0;
    else if (en)  crc <= crc8_next(seed, din);
    else if (clr) crc <= '0;
  end
endmodule

// File: rtl/yas_packet_rx.sv
// YAS router input stage: byte handshake, header routing, per-channel writes.
// Trailing CRC-8 check is compiled in only when YAS_RX_CRC_EN is defined.
module yas_packet_rx
  import yas_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_req,
  output logic                  data_in_ack,
  input  logic [1:0]            ch0_addr,
  input  logic [1:0]            ch1_addr,
  input  logic [1:0]            ch2_addr,
  input  logic                  crc_en,
  input  logic [NUM_CH-1:0]     out_ready,
  output logic [DATA_WIDTH-1:0] pkt_data,
  output logic                  pkt_wr,
  output logic [NUM_CH-1:0]     pkt_ch,
  output logic                  pkt_sop,
  output logic                  pkt_eop,
  output logic                  pkt_done,
  output logic                  pkt_bad,
  output logic                  err_no_route
);
  localparam logic [NUM_CH-1:0]    CH_ONE  = 1;
  localparam logic [DATA_SIZE-1:0] LEN_ONE = 1;

  rx_state_e                            state;
  logic [NUM_CH-1:0]                    ch_sel;
  logic [DATA_SIZE-1:0]                 cnt;
  logic                                 crc_lat;
  logic                                 crc_mode;
  logic                                 xfer;
  logic [HDR_ADDR_W-1:0]                hdr_addr;
  logic [DATA_SIZE-1:0]                 hdr_len;
  logic [NUM_CH-1:0][HDR_ADDR_W-1:0]    ch_addr;
  logic [NUM_CH-1:0]                    hit;
  logic [NUM_CH-1:0]                    hit_oh;
  logic                                 hit_any;

  assign hdr_addr = data_in[HDR_ADDR_LSB +: HDR_ADDR_W];
  assign hdr_len  = data_in[HDR_LEN_LSB +: DATA_SIZE];
  assign ch_addr  = {ch2_addr, ch1_addr, ch0_addr};

  // Lowest channel index wins when several addresses are equal.
  always_comb begin
    hit_oh = '0;
    for (int i = 0; i < NUM_CH; i++) hit[i] = (ch_addr[i] == hdr_addr);
    for (int i = NUM_CH-1; i >= 0; i--)
      if (hit[i]) hit_oh = CH_ONE << i;
  end

  assign hit_any = |hit;

  always_comb begin
    data_in_ack = 1'b1;
    case (state)
      ST_IDLE:    data_in_ack = hit_any ? |(out_ready & hit_oh) : 1'b1;
      ST_PAYLOAD: data_in_ack = |(out_ready & ch_sel);
      default:    data_in_ack = 1'b1;
    endcase
  end

  assign xfer = data_in_req & data_in_ack;

`ifdef YAS_RX_CRC_EN
  logic [DATA_WIDTH-1:0] crc_q;
  logic                  crc_clr;
  logic                  crc_upd;

  assign crc_mode = crc_en;
  assign crc_clr  = (state == ST_IDLE);
  assign crc_upd  = xfer & (((state == ST_IDLE) & hit_any) | (state == ST_PAYLOAD));

  yas_crc8 u_crc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (crc_clr),
    .en    (crc_upd),
    .din   (data_in),
    .crc   (crc_q)
  );
`else
  logic unused_crc_en;
  assign unused_crc_en = crc_en;
  assign crc_mode      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      ch_sel       <= '0;
      cnt          <= '0;
      crc_lat      <= 1'b0;
      pkt_data     <= '0;
      pkt_wr       <= 1'b0;
      pkt_ch       <= '0;
      pkt_sop      <= 1'b0;
      pkt_eop      <= 1'b0;
      pkt_done     <= 1'b0;
      pkt_bad      <= 1'b0;
      err_no_route <= 1'b0;
    end else begin
      pkt_wr       <= 1'b0;
      pkt_sop      <= 1'b0;
      pkt_eop      <= 1'b0;
      pkt_done     <= 1'b0;
      pkt_bad      <= 1'b0;
      err_no_route <= 1'b0;
      case (state)
        ST_IDLE: if (xfer) begin
          cnt     <= hdr_len;
          crc_lat <= crc_mode;
          if (hit_any) begin
            ch_sel   <= hit_oh;
            pkt_wr   <= 1'b1;
            pkt_data <= data_in;
            pkt_ch   <= hit_oh;
            pkt_sop  <= 1'b1;
            state    <= ST_PAYLOAD;
          end else begin
            err_no_route <= 1'b1;
            state        <= ST_DROP;
          end
        end
        ST_PAYLOAD: if (xfer) begin
          pkt_wr   <= 1'b1;
          pkt_data <= data_in;
          pkt_ch   <= ch_sel;
          cnt      <= cnt - LEN_ONE;
          if (cnt == '0) begin
            pkt_eop <= 1'b1;
            if (crc_lat) begin
              state <= ST_CRC;
            end else begin
              pkt_done <= 1'b1;
              state    <= ST_IDLE;
            end
          end
        end
`ifdef YAS_RX_CRC_EN
        ST_CRC: if (xfer) begin
          pkt_done <= 1'b1;
          pkt_bad  <= (data_in != crc_q);
          state    <= ST_IDLE;
        end
`endif
        // The trailing CRC byte of a dropped packet is swallowed by clearing
        // crc_lat and staying one more byte with the counter at zero.
        ST_DROP: if (xfer) begin
          if (cnt == '0) begin
            if (crc_lat) crc_lat <= 1'b0;
            else         state   <= ST_IDLE;
          end else begin
            cnt <= cnt - LEN_ONE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_yas_packet_rx.sv
// Directed bench for yas_packet_rx; CRC scenarios follow YAS_RX_CRC_EN.
module tb_yas_packet_rx;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] data_in = '0;
  logic       data_in_req = 1'b0;
  logic       data_in_ack;
  logic [1:0] ch0_addr = 2'd0, ch1_addr = 2'd1, ch2_addr = 2'd2;
  logic       crc_en = 1'b0;
  logic [2:0] out_ready = 3'b111;
  logic [7:0] pkt_data;
  logic       pkt_wr, pkt_sop, pkt_eop, pkt_done, pkt_bad, err_no_route;
  logic [2:0] pkt_ch;

  int   n_cmp = 0, n_err = 0;
  logic last_ack;
  logic [5:0] flags;

  assign flags = {pkt_wr, pkt_sop, pkt_eop, pkt_done, pkt_bad, err_no_route};

  always #5 clk = ~clk;

  yas_packet_rx dut (
    .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_req(data_in_req),
    .data_in_ack(data_in_ack), .ch0_addr(ch0_addr), .ch1_addr(ch1_addr),
    .ch2_addr(ch2_addr), .crc_en(crc_en), .out_ready(out_ready),
    .pkt_data(pkt_data), .pkt_wr(pkt_wr), .pkt_ch(pkt_ch), .pkt_sop(pkt_sop),
    .pkt_eop(pkt_eop), .pkt_done(pkt_done), .pkt_bad(pkt_bad),
    .err_no_route(err_no_route)
  );

  // One clock: drive at negedge, sample ack before the edge, land on next negedge.
  task automatic step(input logic [7:0] d, input logic r);
    data_in = d; data_in_req = r;
    #1 last_ack = data_in_ack;
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (flags !== 6'b0) begin n_err++; $display("FAIL reset_flags got %b want 000000", flags); end
    n_cmp++; if ({pkt_data, pkt_ch} !== 11'b0) begin n_err++; $display("FAIL reset_data_ch got %h/%b want 00/000", pkt_data, pkt_ch); end
    n_cmp++; if (data_in_ack !== 1'b1) begin n_err++; $display("FAIL reset_ack got %b want 1", data_in_ack); end
    rst_n = 1'b1;
    step(8'h00, 1'b0);
  endtask

  task automatic test_basic();
    logic [7:0] b [4];
    logic [5:0] exp;
    b = '{8'h42, 8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 4; i++) begin
      step(b[i], 1'b1);
      exp = {1'b1, (i == 0), (i == 3), (i == 3), 2'b00};
      n_cmp++; if (flags !== exp) begin n_err++; $display("FAIL basic_flags[%0d] got %b want %b", i, flags, exp); end
      n_cmp++; if ({pkt_data, pkt_ch, last_ack} !== {b[i], 3'b010, 1'b1}) begin n_err++;
        $display("FAIL basic_data[%0d] got %h/%b/%b want %h/010/1", i, pkt_data, pkt_ch, last_ack, b[i]); end
    end
    step(8'h00, 1'b0);
    n_cmp++; if (flags !== 6'b0) begin n_err++; $display("FAIL basic_idle got %b want 000000", flags); end
  endtask

  task automatic test_no_route();
    step(8'hC0, 1'b1);
    n_cmp++; if ({flags, last_ack} !== 7'b0000011) begin n_err++; $display("FAIL noroute_hdr got %b/%b want 000001/1", flags, last_ack); end
    step(8'h99, 1'b1);
    n_cmp++; if ({flags, last_ack} !== 7'b0000001) begin n_err++; $display("FAIL noroute_drop got %b/%b want 000000/1", flags, last_ack); end
    step(8'h00, 1'b1);
    n_cmp++; if ({flags, pkt_ch} !== 9'b110000_001) begin n_err++; $display("FAIL noroute_next_hdr got %b/%b want 110000/001", flags, pkt_ch); end
    step(8'h5A, 1'b1);
    n_cmp++; if ({flags, pkt_data} !== {6'b101100, 8'h5A}) begin n_err++; $display("FAIL noroute_next_eop got %b/%h want 101100/5a", flags, pkt_data); end
    step(8'h00, 1'b0);
  endtask

`ifdef YAS_RX_CRC_EN
  task automatic test_crc();
    logic [7:0] cb;
    crc_en = 1'b1;
    for (int p = 0; p < 2; p++) begin
      cb = (p == 0) ? 8'h5D : 8'hA2;
      step(8'h01, 1'b1);
      n_cmp++; if ({flags, pkt_ch} !== 9'b110000_001) begin n_err++; $display("FAIL crc_hdr[%0d] got %b/%b want 110000/001", p, flags, pkt_ch); end
      step(8'hAA, 1'b1);
      step(8'h55, 1'b1);
      n_cmp++; if (flags !== 6'b101000) begin n_err++; $display("FAIL crc_eop[%0d] got %b want 101000", p, flags); end
      step(cb, 1'b1);
      n_cmp++; if ({flags, last_ack} !== {4'b0001, (p == 1), 2'b01}) begin n_err++;
        $display("FAIL crc_verdict[%0d] got %b/%b want 0001%0d0/1", p, flags, last_ack, p); end
      n_cmp++; if (pkt_data !== 8'h55) begin n_err++; $display("FAIL crc_not_fwd[%0d] got %h want 55", p, pkt_data); end
      step(8'h00, 1'b0);
    end
    crc_en = 1'b0;
  endtask
`else
  task automatic test_crc();
    crc_en = 1'b1;
    step(8'h01, 1'b1);
    step(8'hAA, 1'b1);
    step(8'h55, 1'b1);
    n_cmp++; if (flags !== 6'b101100) begin n_err++; $display("FAIL nocrc_eop got %b want 101100", flags); end
    step(8'h00, 1'b0);
    n_cmp++; if (flags !== 6'b0) begin n_err++; $display("FAIL nocrc_after got %b want 000000", flags); end
    crc_en = 1'b0;
  endtask
`endif

  task automatic test_stall();
    logic [7:0] b;
    step(8'h04, 1'b1);
    step(8'h10, 1'b1);
    step(8'h11, 1'b1);
    out_ready = 3'b110;
    for (int i = 0; i < 5; i++) begin
      step(8'h12, 1'b1);
      n_cmp++; if ({flags, last_ack} !== 7'b0) begin n_err++; $display("FAIL stall[%0d] got %b/%b want 000000/0", i, flags, last_ack); end
    end
    out_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      b = 8'h12 + 8'(i);
      step(b, 1'b1);
      n_cmp++; if ({flags, pkt_data, pkt_ch} !== {1'b1, 1'b0, (i == 2), (i == 2), 2'b00, b, 3'b001}) begin n_err++;
        $display("FAIL stall_resume[%0d] got %b/%h/%b want eop=%0d/%h/001", i, flags, pkt_data, pkt_ch, (i == 2), b); end
    end
    step(8'h00, 1'b0);
    n_cmp++; if (flags !== 6'b0) begin n_err++; $display("FAIL stall_dup got %b want 000000", flags); end
  endtask

  task automatic test_config_change();
    step(8'h01, 1'b1);
    ch0_addr = 2'd3; crc_en = 1'b1;
    step(8'hAA, 1'b1);
    n_cmp++; if ({flags, pkt_ch} !== 9'b100000_001) begin n_err++; $display("FAIL cfg_mid got %b/%b want 100000/001", flags, pkt_ch); end
    step(8'hBB, 1'b1);
    n_cmp++; if (flags !== 6'b101100) begin n_err++; $display("FAIL cfg_old_mode got %b want 101100", flags); end
    step(8'hC0, 1'b1);
    n_cmp++; if ({flags, pkt_ch} !== 9'b110000_001) begin n_err++; $display("FAIL cfg_new_addr got %b/%b want 110000/001", flags, pkt_ch); end
    step(8'h00, 1'b1);
`ifdef YAS_RX_CRC_EN
    n_cmp++; if (flags !== 6'b101000) begin n_err++; $display("FAIL cfg_new_crc_eop got %b want 101000", flags); end
    step(8'hED, 1'b1);
    n_cmp++; if (flags !== 6'b000100) begin n_err++; $display("FAIL cfg_new_crc_ok got %b want 000100", flags); end
`else
    n_cmp++; if (flags !== 6'b101100) begin n_err++; $display("FAIL cfg_new_eop got %b want 101100", flags); end
`endif
    ch0_addr = 2'd0; crc_en = 1'b0;
    step(8'h00, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [7:0] b [5];
    logic [5:0] e [5];
    b = '{8'h80, 8'h77, 8'h81, 8'h01, 8'h02};
    e = '{6'b110000, 6'b101100, 6'b110000, 6'b100000, 6'b101100};
    for (int i = 0; i < 5; i++) begin
      step(b[i], 1'b1);
      n_cmp++; if ({flags, pkt_data, pkt_ch} !== {e[i], b[i], 3'b100}) begin n_err++;
        $display("FAIL b2b[%0d] got %b/%h/%b want %b/%h/100", i, flags, pkt_data, pkt_ch, e[i], b[i]); end
    end
    step(8'h00, 1'b0);
  endtask

  task automatic test_reset_mid();
    logic [5:0] exp;
    logic [7:0] b;
    int bad;
    step(8'h45, 1'b1);
    step(8'hA0, 1'b1);
    step(8'hA1, 1'b1);
    rst_n = 1'b0;
    #1;
    n_cmp++; if ({flags, pkt_data, pkt_ch} !== 17'b0) begin n_err++; $display("FAIL rstmid_outs got %b/%h/%b want all 0", flags, pkt_data, pkt_ch); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 65; i++) begin
      b = (i == 0) ? 8'h3F : 8'(i);
      step(b, 1'b1);
      exp = {1'b1, (i == 0), (i == 64), (i == 64), 2'b00};
      n_cmp++; if ({flags, pkt_data, pkt_ch} !== {exp, b, 3'b001}) begin n_err++; bad++;
        if (bad < 4) $display("FAIL rstmid_long[%0d] got %b/%h/%b want %b/%h/001", i, flags, pkt_data, pkt_ch, exp, b); end
    end
    step(8'h00, 1'b0);
    n_cmp++; if (flags !== 6'b0) begin n_err++; $display("FAIL rstmid_tail got %b want 000000", flags); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_route();
    test_crc();
    test_stall();
    test_config_change();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/yas_packet_rx.md
# yas_packet_rx

Input stage of the YAS router: terminates the `data_in`/`data_in_req`/`data_in_ack` byte handshake and parses the packet header. It routes each packet to one of three output channels using the channel addresses from `config_regs`, and writes the bytes into the per-channel output buffers. It also discards unroutable packets and, when compiled in, checks a trailing CRC-8 byte.

## Interface
- `DATA_WIDTH`, 8, byte width.
- `DATA_SIZE`, 6, width of the header length field; max payload 2^DATA_SIZE bytes.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous reset, active low.
- `data_in`  in  DATA_WIDTH  input byte.
- `data_in_req`  in  1  upstream byte valid.
- `data_in_ack`  out  1  byte accepted; combinational.
- `ch0_addr`/`ch1_addr`/`ch2_addr`  in  2 each  channel addresses from `config_regs`.
- `crc_en`  in  1  runtime CRC enable from `config_regs`.
- `out_ready`  in  3  per-channel buffer can take one more byte.
- `pkt_data`  out  DATA_WIDTH  byte to the buffer.
- `pkt_wr`  out  1  write strobe.
- `pkt_ch`  out  3  one-hot target channel.
- `pkt_sop`, `pkt_eop`  out  1  first/last byte markers qualified by `pkt_wr`.
- `pkt_done`  out  1  one-cycle packet-complete strobe.
- `pkt_bad`  out  1  qualified by `pkt_done`; buffer discards the packet.
- `err_no_route`  out  1  one-cycle pulse when a header matches no channel.

## Operation
- Transfer happens on a cycle with `data_in_req && data_in_ack`.
- Header byte layout:
  - `[7:6]` = destination address.
  - `[5:0]` = L; the payload is L+1 bytes (1..64).
- Header match priority is ch0 > ch1 > ch2; the first equal `chN_addr` wins.
- States:
  - IDLE: waits for a header. `data_in_ack` = `out_ready` of the matched channel, or 1 if no match. On transfer:
    - match: latch channel, length and `crc_en`; forward the header with `pkt_sop`; go to PAYLOAD.
    - no match: pulse `err_no_route`; go to DROP.
  - PAYLOAD: `data_in_ack` = `out_ready[ch]`. Each byte is forwarded and the down-counter decrements. On the last byte, `pkt_eop` is set and the next state is CRC if latched crc_en, else IDLE with `pkt_done`=1 and `pkt_bad`=0 on the same output cycle as the eop write.
  - CRC: `data_in_ack`=1. The byte is not forwarded. It is compared with the running CRC; `pkt_done` and `pkt_bad`=mismatch are issued; next state is IDLE.
  - DROP: `data_in_ack`=1. Consumes L+1 bytes, plus one CRC byte if `crc_en` was latched. No writes. Returns to IDLE.
- CRC-8:
  - polynomial 0x07, init 0x00, MSB first, no reflection, no xorout.
  - Covers the header plus the payload.
- Channel, length and crc_en are latched at the header. Config changes mid-packet do not affect the current packet.
- `out_ready` deasserting mid-packet stalls; there is no timeout.
- Reset mid-packet: the FSM returns to IDLE and the partial packet is abandoned. The downstream buffer is reset by the same `rst_n`.

## Timing
- All outputs except `data_in_ack` are registered. Each is reset to 0: `pkt_data`, `pkt_wr`, `pkt_ch`, `pkt_sop`, `pkt_eop`, `pkt_done`, `pkt_bad`, `err_no_route`.
- `data_in_ack` is 1 while `rst_n` is low (state IDLE, no match pending) but no transfer occurs during reset.
- Latency: accepted byte at cycle n gives `pkt_wr` at n+1.
- The CRC verdict comes as `pkt_done` at n+1 after the CRC byte.
- Throughput: one byte/cycle, back-to-back packets included. A header may be accepted in the cycle after the eop byte or the CRC byte.
- `pkt_wr` is a single-cycle strobe per byte.
- `out_ready` must already account for the one write in flight; this is the buffer's responsibility.

## Configuration
- Macro: `YAS_RX_CRC_EN`.
- Defined: CRC logic present; the CRC state and `crc_en` behave as above.
- Undefined: `crc_en` is ignored, the CRC state and CRC logic are absent, and no CRC byte is expected. `pkt_done` always accompanies eop and `pkt_bad` is tied to 0.

## Structure
- The shared package `yas_pkg` holds:
  - the `DATA_WIDTH`/`DATA_SIZE` constants;
  - the rx state enum (IDLE, PAYLOAD, CRC, DROP);
  - the header field positions;
  - the CRC polynomial constant.
- One sub-module, `yas_crc8`: byte-wide combinational next-CRC with a clear/enable register. It is instantiated only under `YAS_RX_CRC_EN`.

## Test plan
- ch0=0,ch1=1,ch2=2, crc off; header 0x42 plus 3 payload bytes, req held high:
  - 4 writes to pkt_ch=3'b010 on consecutive cycles;
  - sop on 0x42, eop on the 3rd payload byte;
  - `pkt_done`=1, `pkt_bad`=0 with eop.
- Header 0xC0 with no channel at addr 3:
  - `err_no_route` pulses;
  - the next 1 byte is acked with no `pkt_wr`;
  - the following header is routed normally.
- crc on; header 0x01 plus payload 0xAA, 0x55, then the correct CRC byte:
  - `pkt_done`=1, `pkt_bad`=0;
  - the same packet with the CRC byte inverted gives `pkt_bad`=1;
  - the CRC byte never appears on `pkt_data`.
- `out_ready[0]` dropped for 5 cycles mid-payload to ch0:
  - `data_in_ack`=0 and no `pkt_wr` for those cycles;
  - no byte is lost or duplicated after resume.
- Change `ch0_addr` and `crc_en` mid-packet: the current packet keeps its channel and CRC mode; the next header uses the new values.
- Assert `rst_n` low after 2 payload bytes: all outputs go to 0. After release, a fresh 64-byte packet (L=63) is routed with eop on byte 65.
